// File: rtl/song_sequencer.sv
// Note sequencer: plays a writable song memory of {note_code, dur} entries at a programmable tempo,
// producing the selected note-table word on songout.
module song_sequencer #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned NOTE_W = 16,
    parameter int unsigned DIV_W  = 24,
    parameter int unsigned DUR_W  = 4
) (
    input  logic                   clk50,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [6+DUR_W-1:0]     wr_data,
    input  logic [36*NOTE_W-1:0]   note_tbl,
    input  logic [ADDR_W-1:0]      song_len,
    input  logic [DIV_W-1:0]       tempo_div,
    input  logic                   play,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   loop_en,
    output logic [NOTE_W-1:0]      songout,
    output logic [ADDR_W-1:0]      note_addr,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned ENT_W = 6 + DUR_W;

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StHold, StDone} state_e;

    state_e            state;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rd_data;
    logic [5:0]        rd_code;
    logic [NOTE_W-1:0] rd_note;
    logic [DIV_W-1:0]  tick_cnt;
    logic [DIV_W-1:0]  div_m1;
    logic [DUR_W-1:0]  dur_cnt;
    logic              tick;

    // Read-before-write: a same-address write in the read cycle returns the old entry.
    always_ff @(posedge clk50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[note_addr];
    end

    assign rd_code = rd_data[ENT_W-1:DUR_W];

    // Codes outside 1..36 are rests.
    always_comb begin
        rd_note = '0;
        for (int k = 1; k <= 36; k++) begin
            if (rd_code == 6'(k)) begin
                rd_note = note_tbl[(k-1)*NOTE_W +: NOTE_W];
            end
        end
    end

    assign div_m1 = (tempo_div == '0) ? '0 : tempo_div - DIV_W'(1);
    assign tick   = (tick_cnt >= div_m1);

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            songout   <= '0;
            note_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tick_cnt  <= '0;
            dur_cnt   <= '0;
        end else if (stop) begin
            state    <= StIdle;
            songout  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (play) begin
                        state     <= StFetch;
                        note_addr <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                StFetch: state <= StLoad;
                StLoad: begin
                    songout  <= rd_note;
                    dur_cnt  <= rd_data[DUR_W-1:0];
                    tick_cnt <= '0;
                    state    <= StHold;
                end
                StHold: begin
                    if (!pause) begin
                        if (!tick) begin
                            tick_cnt <= tick_cnt + DIV_W'(1);
                        end else begin
                            tick_cnt <= '0;
                            if (dur_cnt != '0) begin
                                dur_cnt <= dur_cnt - DUR_W'(1);
                            end else if (note_addr != song_len) begin
                                note_addr <= note_addr + ADDR_W'(1);
                                state     <= StFetch;
                            end else if (loop_en) begin
                                note_addr <= '0;
                                state     <= StFetch;
                            end else begin
                                state   <= StDone;
                                songout <= '0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: a note-by-note schedule model checked every cycle, directed scenarios
// with hand-computed expectations, then randomized play/stop/pause/write/reset traffic.
module tb_song_sequencer;
    localparam int ADDR_W = 9;
    localparam int NOTE_W = 16;
    localparam int DIV_W  = 24;
    localparam int DUR_W  = 4;
    localparam int DEPTH  = 512;

    logic                  clk50 = 1'b0;
    logic                  reset = 1'b1;
    logic                  wr_en = 1'b0;
    logic [ADDR_W-1:0]     wr_addr = '0;
    logic [9:0]            wr_data = '0;
    logic [36*NOTE_W-1:0]  note_tbl = '0;
    logic [ADDR_W-1:0]     song_len = '0;
    logic [DIV_W-1:0]      tempo_div = '0;
    logic                  play = 1'b0;
    logic                  stop = 1'b0;
    logic                  pause = 1'b0;
    logic                  loop_en = 1'b0;
    logic [NOTE_W-1:0]     songout;
    logic [ADDR_W-1:0]     note_addr;
    logic                  busy;
    logic                  done;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    song_sequencer #(
        .ADDR_W (ADDR_W),
        .NOTE_W (NOTE_W),
        .DIV_W  (DIV_W),
        .DUR_W  (DUR_W)
    ) dut (
        .clk50     (clk50),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .note_tbl  (note_tbl),
        .song_len  (song_len),
        .tempo_div (tempo_div),
        .play      (play),
        .stop      (stop),
        .pause     (pause),
        .loop_en   (loop_en),
        .songout   (songout),
        .note_addr (note_addr),
        .busy      (busy),
        .done      (done)
    );

    initial forever #10 clk50 = ~clk50;

    // Model: phase 0 idle, 1 fetch, 2 load, 3 hold, 4 done; a note is a block of hold cycles.
    int unsigned tbl [37];
    logic [9:0]  mem [DEPTH];
    int          m_phase = 0;
    int          m_addr  = 0;
    int          m_left  = 0;
    logic [15:0] m_song  = '0;
    logic [9:0]  m_rd    = '0;

    function automatic logic [15:0] tbl_of(logic [5:0] c);
        if (c >= 6'd1 && c <= 6'd36) return 16'(tbl[c]);
        return 16'h0;
    endfunction

    task automatic model_step();
        int div;
        if (!reset) begin
            m_phase = 0;
            m_song  = '0;
            m_addr  = 0;
        end else begin
            div = (tempo_div == '0) ? 1 : int'(tempo_div);
            if (stop) begin
                m_phase = 0;
                m_song  = '0;
            end else begin
                case (m_phase)
                    0, 4: if (play) begin m_phase = 1; m_addr = 0; end
                    1: begin m_rd = mem[m_addr]; m_phase = 2; end
                    2: begin
                        m_song  = tbl_of(m_rd[9:4]);
                        m_left  = (int'(m_rd[3:0]) + 1) * div;
                        m_phase = 3;
                    end
                    3: if (!pause) begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_addr != int'(song_len)) begin
                                m_addr  = (m_addr + 1) % DEPTH;
                                m_phase = 1;
                            end else if (loop_en) begin
                                m_addr  = 0;
                                m_phase = 1;
                            end else begin
                                m_phase = 4;
                                m_song  = '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (wr_en) mem[wr_addr] = wr_data;
        end
    endtask

    initial forever begin
        @(posedge clk50 or negedge reset);
        model_step();
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk50);
        if (chk_en) begin
            chk("songout",   32'(songout),   32'(m_song));
            chk("note_addr", 32'(note_addr), 32'(m_addr));
            chk("busy",      32'(busy),      32'(m_phase >= 1 && m_phase <= 3));
            chk("done",      32'(done),      32'(m_phase == 4));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic pulse_play();
        #1 play = 1'b1;
        @(negedge clk50);
        #1 play = 1'b0;
    endtask

    task automatic pulse_stop();
        #1 stop = 1'b1;
        @(negedge clk50);
        #1 stop = 1'b0;
    endtask

    task automatic wr(int a, logic [9:0] d);
        @(negedge clk50);
        #1;
        wr_en   = 1'b1;
        wr_addr = 9'(a);
        wr_data = d;
    endtask

    task automatic wr_done();
        @(negedge clk50);
        #1 wr_en = 1'b0;
    endtask

    task automatic load_tbl();
        for (int k = 1; k <= 36; k++) note_tbl[(k-1)*NOTE_W +: NOTE_W] = 16'(tbl[k]);
    endtask

    initial begin
        tbl[0] = 0;
        for (int k = 1; k <= 36; k++) tbl[k] = k * 100;
        load_tbl();

        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_songout", 32'(songout), 32'd0);
        chk("rst_addr",    32'(note_addr), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_done",    32'(done), 32'd0);
        cyc(2);
        #1 reset = 1'b1;

        // Whole memory with one-tick notes, then play through the address wrap.
        for (int a = 0; a < DEPTH; a++) wr(a, {6'($urandom_range(0, 63)), 4'd0});
        wr_done();
        song_len  = 9'd511;
        tempo_div = 24'd1;
        loop_en   = 1'b1;
        pulse_play();
        cyc(1535);
        chk("wrap_last_addr", 32'(note_addr), 32'd511);
        cyc(1);
        chk("wrap_addr0", 32'(note_addr), 32'd0);
        chk("wrap_busy",  32'(busy), 32'd1);
        cyc(10);
        pulse_stop();

        wr(0, {6'd1, 4'd0});
        wr(1, {6'd8, 4'd1});
        wr(2, {6'd0, 4'd0});
        wr_done();
        song_len  = 9'd2;
        tempo_div = 24'd10;
        loop_en   = 1'b0;

        // One-shot playback.
        pulse_play();
        cyc(2);  chk("p1_first", 32'(songout), 32'd100);
        cyc(9);  chk("p1_e0_end", 32'(songout), 32'd100);
        cyc(1);  chk("p1_gap_hold", 32'(songout), 32'd100);
                 chk("p1_gap_busy", 32'(busy), 32'd1);
        cyc(2);  chk("p1_e1", 32'(songout), 32'd800);
        cyc(19); chk("p1_e1_end", 32'(songout), 32'd800);
        cyc(3);  chk("p1_rest", 32'(songout), 32'd0);
        cyc(9);  chk("p1_not_done", 32'(done), 32'd0);
        cyc(1);  chk("p1_done", 32'(done), 32'd1);
                 chk("p1_idle_busy", 32'(busy), 32'd0);

        // Looping playback returns to entry 0.
        loop_en = 1'b1;
        pulse_play();
        cyc(48);
        chk("loop_addr", 32'(note_addr), 32'd0);
        chk("loop_song", 32'(songout), 32'd100);
        chk("loop_done", 32'(done), 32'd0);
        pulse_stop();
        loop_en = 1'b0;

        // Stop mid-note, then restart from entry 0.
        pulse_play();
        cyc(20);
        pulse_stop();
        chk("stop_song", 32'(songout), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        pulse_play();
        cyc(2);
        chk("restart_song", 32'(songout), 32'd100);
        chk("restart_addr", 32'(note_addr), 32'd0);
        pulse_stop();

        // Pause for 37 cycles inside entry 1 stretches it to 57 cycles.
        pulse_play();
        cyc(20);
        #1 pause = 1'b1;
        cyc(37);
        #1 pause = 1'b0;
        cyc(13); chk("pause_e1_end", 32'(songout), 32'd800);
        cyc(3);  chk("pause_rest", 32'(songout), 32'd0);
        pulse_stop();

        // Asynchronous reset mid-note; memory survives.
        pulse_play();
        cyc(15);
        #1 reset = 1'b0;
        #1;
        chk("arst_song", 32'(songout), 32'd0);
        chk("arst_addr", 32'(note_addr), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        cyc(1);
        #1 reset = 1'b1;
        pulse_play();
        cyc(14);
        chk("replay_e1", 32'(songout), 32'd800);
        pulse_stop();

        // Randomized traffic; tempo only changes alongside stop or reset.
        for (int k = 1; k <= 36; k++) tbl[k] = $urandom_range(1, 65535);
        load_tbl();
        for (int it = 0; it < 25; it++) begin
            tempo_div = 24'($urandom_range(0, 4));
            song_len  = 9'($urandom_range(0, 6));
            loop_en   = 1'($urandom_range(0, 1));
            pulse_stop();
            for (int c = 0; c < 400; c++) begin
                @(negedge clk50);
                #1;
                reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                play  = ($urandom_range(0, 19) == 0);
                stop  = ($urandom_range(0, 99) == 0);
                if (stop || !reset) tempo_div = 24'($urandom_range(0, 4));
                if ($urandom_range(0, 9) == 0) pause = ~pause;
                wr_en   = reset && ($urandom_range(0, 9) == 0);
                wr_addr = 9'($urandom_range(0, 7));
                wr_data = {6'($urandom_range(0, 63)), 4'($urandom_range(0, 3))};
                if ($urandom_range(0, 49) == 0) song_len = 9'($urandom_range(0, 7));
                if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
            end
            @(negedge clk50);
            #1;
            reset = 1'b1;
            play  = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
            pause = 1'b0;
        end

        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
